fe_bus_arbiter: RTL

//   Two-master round-robin arbiter sharing one frontend memory bus (valid/ready

---
 rtl/fe_bus_arbiter_if.sv | 17 +
 rtl/fe_bus_arbiter.sv | 78 +++++++
 2 files changed

// File: rtl/fe_bus_arbiter_if.sv
// fe_bus_arbiter_if: valid/ready request plus delayed rvalid read response bus.
interface fe_bus_arbiter_if #(
    parameter int ADDR_W = 22,
    parameter int DATA_W = 32,
    parameter int STRB_W = 4
);
    logic              valid;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
    logic              ready;
    logic [DATA_W-1:0] rdata;
    logic              rvalid;

    modport master (output valid, addr, wdata, wstrb, input ready, rdata, rvalid);
    modport slave  (input valid, addr, wdata, wstrb, output ready, rdata, rvalid);
endinterface

// File: rtl/fe_bus_arbiter.sv
// fe_bus_arbiter: two-master round-robin arbiter, grant held for a whole
// transaction (writes end on ready, reads end on rvalid).
module fe_bus_arbiter #(
    parameter int ADDR_W = 22,
    parameter int DATA_W = 32,
    parameter int STRB_W = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    fe_bus_arbiter_if.slave  m0,
    fe_bus_arbiter_if.slave  m1,
    fe_bus_arbiter_if.master s,
    output logic        owner,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, GRANT, WAIT_R} state_t;

    state_t            state;
    logic              rr_last;
    logic              grant;
    logic              wait_r;
    logic              o_valid;
    logic [ADDR_W-1:0] o_addr;
    logic [DATA_W-1:0] o_wdata;
    logic [STRB_W-1:0] o_wstrb;

    always_comb begin
        grant   = state == GRANT;
        wait_r  = state == WAIT_R;
        o_valid = owner ? m1.valid : m0.valid;
        o_addr  = owner ? m1.addr  : m0.addr;
        o_wdata = owner ? m1.wdata : m0.wdata;
        o_wstrb = owner ? m1.wstrb : m0.wstrb;
    end

    // s_valid drops with s_ready so the slave never takes the same request twice
    assign s.valid   = grant & o_valid & ~s.ready;
    assign s.addr    = grant ? o_addr  : '0;
    assign s.wdata   = grant ? o_wdata : '0;
    assign s.wstrb   = grant ? o_wstrb : '0;
    assign m0.ready  = grant & ~owner & s.ready;
    assign m1.ready  = grant &  owner & s.ready;
    assign m0.rvalid = wait_r & ~owner & s.rvalid;
    assign m1.rvalid = wait_r &  owner & s.rvalid;
    assign m0.rdata  = rst_n ? s.rdata : '0;
    assign m1.rdata  = rst_n ? s.rdata : '0;
    assign busy      = state != IDLE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            owner   <= 1'b0;
            rr_last <= 1'b1;
        end else begin
            case (state)
                IDLE: if (m0.valid | m1.valid) begin
                    owner <= (m0.valid & m1.valid) ? ~rr_last : m1.valid;
                    state <= GRANT;
                end
                GRANT: if (s.ready) begin
                    if (|o_wstrb) begin
                        rr_last <= owner;
                        state   <= IDLE;
                    end else begin
                        state <= WAIT_R;
                    end
                end else if (!o_valid) begin
                    state <= IDLE;
                end
                WAIT_R: if (s.rvalid) begin
                    rr_last <= owner;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
